// File: rtl/fc_layer_sequencer_if.sv
// Parameter-memory read ports (bias, weight, activation) and the result stream
// of one fully-connected layer; master is the sequencer, slave the memories/sink.
interface fc_layer_sequencer_if #(
   parameter int N_IN   = 120,
   parameter int N_OUT  = 84,
   parameter int DATA_W = 16,
   parameter int W_AW   = 14
);
   localparam int OA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int IA_W = (N_IN > 1) ? $clog2(N_IN) : 1;

   logic              b_rd_en;
   logic [OA_W-1:0]   b_addr;
   logic [DATA_W-1:0] b_data;

   logic              w_rd_en;
   logic [W_AW-1:0]   w_addr;
   logic [DATA_W-1:0] w_data;

   logic              x_rd_en;
   logic [IA_W-1:0]   x_addr;
   logic [DATA_W-1:0] x_data;

   logic              y_valid;
   logic              y_ready;
   logic [OA_W-1:0]   y_addr;
   logic [DATA_W-1:0] y_data;

   modport master (
      output b_rd_en, b_addr, w_rd_en, w_addr, x_rd_en, x_addr,
             y_valid, y_addr, y_data,
      input  b_data, w_data, x_data, y_ready
   );

   modport slave (
      input  b_rd_en, b_addr, w_rd_en, w_addr, x_rd_en, x_addr,
             y_valid, y_addr, y_data,
      output b_data, w_data, x_data, y_ready
   );
endinterface

// File: rtl/fc_layer_sequencer.sv
// One fully-connected layer: reads bias, weights and activations per neuron,
// accumulates in a wide signed register and streams saturated Q-format results.
module fc_layer_sequencer #(
   parameter int N_IN   = 120,
   parameter int N_OUT  = 84,
   parameter int DATA_W = 16,
   parameter int FRAC   = 8,
   parameter int ACC_W  = 40,
   parameter int W_AW   = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 relu_en,
   output logic                 busy,
   output logic                 done,
   fc_layer_sequencer_if.master bus
);
   localparam int OA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int IA_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int P_W  = 2 * DATA_W;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BIAS  = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_OUT   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic                    relu_q, relu_d;
   logic [OA_W-1:0]         o_q, o_d;
   logic [W_AW-1:0]         w_base_q, w_base_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    b_rd_en_q, b_rd_en_d;
   logic [OA_W-1:0]         b_addr_q, b_addr_d;
   logic                    w_rd_en_q, w_rd_en_d;
   logic [W_AW-1:0]         w_addr_q, w_addr_d;
   logic                    x_rd_en_q, x_rd_en_d;
   logic [IA_W-1:0]         x_addr_q, x_addr_d;
   logic                    y_valid_q, y_valid_d;
   logic [OA_W-1:0]         y_addr_q, y_addr_d;
   logic [DATA_W-1:0]       y_data_q, y_data_d;

   logic signed [P_W-1:0]   w_ext, x_ext, prod;
   logic signed [ACC_W-1:0] prod_ext, bias_ext;
   logic [IA_W-1:0]         i_next;

   // Drop the fraction, clamp to the output word range, then optional ReLU.
   function automatic logic [DATA_W-1:0] shape_result(input logic signed [ACC_W-1:0] a,
                                                      input logic relu);
      logic signed [ACC_W-1:0] r;
      logic [ACC_W-DATA_W:0]   top;
      logic [DATA_W-1:0]       y;
      r   = a >>> FRAC;
      top = r[ACC_W-1:DATA_W-1];
      if ((&top) || !(|top)) begin
         y = r[DATA_W-1:0];
      end else if (r[ACC_W-1]) begin
         y = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         y = {1'b0, {(DATA_W-1){1'b1}}};
      end
      if (relu && y[DATA_W-1]) begin
         y = '0;
      end
      return y;
   endfunction

   always_comb begin
      w_ext    = P_W'($signed(bus.w_data));
      x_ext    = P_W'($signed(bus.x_data));
      prod     = w_ext * x_ext;
      prod_ext = ACC_W'(prod);
      bias_ext = ACC_W'($signed(bus.b_data)) <<< FRAC;
      i_next   = x_addr_q + IA_W'(1);

      state_d   = state_q;
      relu_d    = relu_q;
      o_d       = o_q;
      w_base_d  = w_base_q;
      acc_d     = acc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      b_rd_en_d = 1'b0;
      b_addr_d  = b_addr_q;
      w_rd_en_d = 1'b0;
      w_addr_d  = w_addr_q;
      x_rd_en_d = 1'b0;
      x_addr_d  = x_addr_q;
      y_valid_d = y_valid_q;
      y_addr_d  = y_addr_q;
      y_data_d  = y_data_q;

      // Outputs are registered, so each transition also sets up the strobes
      // and addresses of the state being entered.
      case (state_q)
         S_IDLE: begin
            busy_d    = 1'b0;
            y_valid_d = 1'b0;
            if (start) begin
               state_d   = S_BIAS;
               relu_d    = relu_en;
               o_d       = '0;
               w_base_d  = '0;
               busy_d    = 1'b1;
               b_rd_en_d = 1'b1;
               b_addr_d  = '0;
            end
         end
         S_BIAS: begin
            state_d   = S_MAC;
            w_rd_en_d = 1'b1;
            x_rd_en_d = 1'b1;
            x_addr_d  = '0;
            w_addr_d  = w_base_q;
         end
         S_MAC: begin
            if (x_addr_q == '0) begin
               acc_d = bias_ext;
            end else begin
               acc_d = acc_q + prod_ext;
            end
            if (x_addr_q == IA_W'(N_IN - 1)) begin
               state_d = S_DRAIN;
            end else begin
               w_rd_en_d = 1'b1;
               x_rd_en_d = 1'b1;
               x_addr_d  = i_next;
               w_addr_d  = w_base_q + W_AW'(i_next);
            end
         end
         S_DRAIN: begin
            acc_d     = acc_q + prod_ext;
            state_d   = S_OUT;
            y_valid_d = 1'b1;
            y_addr_d  = o_q;
            y_data_d  = shape_result(acc_d, relu_q);
         end
         S_OUT: begin
            if (bus.y_ready) begin
               y_valid_d = 1'b0;
               if (o_q == OA_W'(N_OUT - 1)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = S_BIAS;
                  o_d       = o_q + OA_W'(1);
                  w_base_d  = w_base_q + W_AW'(N_IN);
                  b_rd_en_d = 1'b1;
                  b_addr_d  = o_q + OA_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         relu_q    <= 1'b0;
         o_q       <= '0;
         w_base_q  <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         b_rd_en_q <= 1'b0;
         b_addr_q  <= '0;
         w_rd_en_q <= 1'b0;
         w_addr_q  <= '0;
         x_rd_en_q <= 1'b0;
         x_addr_q  <= '0;
         y_valid_q <= 1'b0;
         y_addr_q  <= '0;
         y_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         relu_q    <= relu_d;
         o_q       <= o_d;
         w_base_q  <= w_base_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         b_rd_en_q <= b_rd_en_d;
         b_addr_q  <= b_addr_d;
         w_rd_en_q <= w_rd_en_d;
         w_addr_q  <= w_addr_d;
         x_rd_en_q <= x_rd_en_d;
         x_addr_q  <= x_addr_d;
         y_valid_q <= y_valid_d;
         y_addr_q  <= y_addr_d;
         y_data_q  <= y_data_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign bus.b_rd_en = b_rd_en_q;
   assign bus.b_addr  = b_addr_q;
   assign bus.w_rd_en = w_rd_en_q;
   assign bus.w_addr  = w_addr_q;
   assign bus.x_rd_en = x_rd_en_q;
   assign bus.x_addr  = x_addr_q;
   assign bus.y_valid = y_valid_q;
   assign bus.y_addr  = y_addr_q;
   assign bus.y_data  = y_data_q;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Drives a 4x3 and a default 120x84 sequencer from bench memories and checks
// every cycle against a dot-product/saturate/ReLU model and cycle-count rules.
`timescale 1ns/1ps
module tb_fc_layer_sequencer;
   localparam int SI = 4;
   localparam int SO = 3;
   localparam int DI = 120;
   localparam int DO = 84;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic s_start, s_relu, s_busy, s_done;
   logic d_start, d_relu, d_busy, d_done;
   logic ready_v [2];

   fc_layer_sequencer_if #(.N_IN(SI), .N_OUT(SO), .DATA_W(16), .W_AW(14)) s_bus ();
   fc_layer_sequencer_if #(.N_IN(DI), .N_OUT(DO), .DATA_W(16), .W_AW(14)) d_bus ();

   assign s_bus.y_ready = ready_v[0];
   assign d_bus.y_ready = ready_v[1];

   fc_layer_sequencer #(.N_IN(SI), .N_OUT(SO), .DATA_W(16), .FRAC(8), .ACC_W(40), .W_AW(14)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(s_start), .relu_en(s_relu),
      .busy(s_busy), .done(s_done), .bus(s_bus)
   );

   fc_layer_sequencer #(.N_IN(DI), .N_OUT(DO), .DATA_W(16), .FRAC(8), .ACC_W(40), .W_AW(14)) dut_d (
      .clk(clk), .rst_n(rst_n), .start(d_start), .relu_en(d_relu),
      .busy(d_busy), .done(d_done), .bus(d_bus)
   );

   logic [15:0] wmem  [2][DI*DO];
   logic [15:0] xmem  [2][DI];
   logic [15:0] bmem  [2][DO];
   logic [15:0] exp_y [2][DO];
   logic [15:0] got_y [2][DO];

   int n_in [2];
   int n_out [2];
   int nxt [2];
   int exp_w [2];
   int stall [2];
   int start_cyc [2];
   int done_rel [2];
   bit active [2];
   bit expect_idle [2];
   bit seen_valid [2];
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Memories with one-cycle latency; unread cycles return noise.
   always @(posedge clk) begin
      s_bus.b_data <= s_bus.b_rd_en ? bmem[0][s_bus.b_addr] : 16'($urandom);
      s_bus.w_data <= s_bus.w_rd_en ? wmem[0][s_bus.w_addr] : 16'($urandom);
      s_bus.x_data <= s_bus.x_rd_en ? xmem[0][s_bus.x_addr] : 16'($urandom);
      d_bus.b_data <= d_bus.b_rd_en ? bmem[1][d_bus.b_addr] : 16'($urandom);
      d_bus.w_data <= d_bus.w_rd_en ? wmem[1][d_bus.w_addr] : 16'($urandom);
      d_bus.x_data <= d_bus.x_rd_en ? xmem[1][d_bus.x_addr] : 16'($urandom);
   end

   task automatic checkValue(input int d, input string name,
                             input logic signed [63:0] act, input logic signed [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL dut%0d %s actual=%0h required=%0h cycle=%0d", d, name, act, req, cyc);
      end
   endtask

   function automatic logic [15:0] refNeuron(input int d, input int o, input logic relu);
      longint acc;
      longint r;
      acc = longint'($signed(bmem[d][o])) * 256;
      for (int i = 0; i < n_in[d]; i++) begin
         acc += longint'($signed(wmem[d][o*n_in[d] + i])) * longint'($signed(xmem[d][i]));
      end
      r = acc >>> 8;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      return r[15:0];
   endfunction

   task automatic computeModel(input int d, input logic relu);
      for (int o = 0; o < n_out[d]; o++) exp_y[d][o] = refNeuron(d, o, relu);
   endtask

   task automatic fillConst(input int d, input logic [15:0] w, input logic [15:0] x, input logic [15:0] b);
      for (int k = 0; k < n_in[d]*n_out[d]; k++) wmem[d][k] = w;
      for (int k = 0; k < n_in[d]; k++) xmem[d][k] = x;
      for (int k = 0; k < n_out[d]; k++) bmem[d][k] = b;
   endtask

   task automatic fillRandom(input int d);
      for (int k = 0; k < n_in[d]*n_out[d]; k++) wmem[d][k] = 16'($urandom_range(0, 1023) - 512);
      for (int k = 0; k < n_in[d]; k++) xmem[d][k] = 16'($urandom_range(0, 1023) - 512);
      for (int k = 0; k < n_out[d]; k++) bmem[d][k] = 16'($urandom_range(0, 4095) - 2048);
   endtask

   task automatic checkLiteral(input int d, input logic [15:0] lit);
      for (int o = 0; o < n_out[d]; o++) checkValue(d, "literal_y", got_y[d][o], lit);
   endtask

   task automatic checkZero(input int d, input logic busy, input logic done, input logic brd,
                            input logic wrd, input logic xrd, input logic yv,
                            input logic [31:0] baddr, input logic [31:0] waddr,
                            input logic [31:0] xaddr, input logic [31:0] yaddr, input logic [15:0] ydata);
      checkValue(d, "rst_busy", busy, 0);
      checkValue(d, "rst_done", done, 0);
      checkValue(d, "rst_b_rd_en", brd, 0);
      checkValue(d, "rst_w_rd_en", wrd, 0);
      checkValue(d, "rst_x_rd_en", xrd, 0);
      checkValue(d, "rst_y_valid", yv, 0);
      checkValue(d, "rst_b_addr", baddr, 0);
      checkValue(d, "rst_w_addr", waddr, 0);
      checkValue(d, "rst_x_addr", xaddr, 0);
      checkValue(d, "rst_y_addr", yaddr, 0);
      checkValue(d, "rst_y_data", ydata, 0);
   endtask

   task automatic checkOutput(input int d, input logic busy, input logic done, input logic brd,
                              input logic wrd, input logic xrd, input logic yv, input logic yr,
                              input logic [31:0] baddr, input logic [31:0] waddr,
                              input logic [31:0] xaddr, input logic [31:0] yaddr, input logic [15:0] ydata);
      int rel;
      if (active[d]) begin
         rel = cyc - start_cyc[d] + 1;
         checkValue(d, "busy", busy, 1);
         if (brd) checkValue(d, "b_addr", baddr, nxt[d]);
         if (wrd || xrd) begin
            checkValue(d, "x_rd_en_pair", xrd, wrd);
            checkValue(d, "w_addr", waddr, exp_w[d]);
            checkValue(d, "x_addr", xaddr, exp_w[d] % n_in[d]);
            exp_w[d]++;
         end
         if (yv) begin
            checkValue(d, "reads_while_valid", {brd, wrd, xrd}, 0);
            if (nxt[d] >= n_out[d]) begin
               checkValue(d, "extra_output", nxt[d], n_out[d] - 1);
            end else begin
               checkValue(d, "y_addr", yaddr, nxt[d]);
               checkValue(d, "y_data", ydata, exp_y[d][nxt[d]]);
               if (!seen_valid[d]) begin
                  seen_valid[d] = 1'b1;
                  checkValue(d, "first_valid_cycle", rel, n_in[d] + 3);
               end
               if (yr) begin
                  got_y[d][nxt[d]] = ydata;
                  nxt[d]++;
               end else begin
                  stall[d]++;
               end
            end
         end
         if (done) begin
            done_rel[d] = rel;
            checkValue(d, "done_cycle", rel, n_out[d]*(n_in[d]+3) + 1 + stall[d]);
            checkValue(d, "outputs_seen", nxt[d], n_out[d]);
            checkValue(d, "weight_reads", exp_w[d], n_in[d]*n_out[d]);
            active[d]      = 1'b0;
            expect_idle[d] = 1'b1;
         end else if (rel > n_out[d]*(n_in[d]+3) + 50 + stall[d]) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d done_timeout actual=none required=done by cycle %0d", d, rel);
            active[d]      = 1'b0;
            expect_idle[d] = 1'b0;
         end
      end else if (expect_idle[d]) begin
         checkValue(d, "idle_busy", busy, 0);
         checkValue(d, "idle_done", done, 0);
         checkValue(d, "idle_y_valid", yv, 0);
         checkValue(d, "idle_reads", {brd, wrd, xrd}, 0);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checkOutput(0, s_busy, s_done, s_bus.b_rd_en, s_bus.w_rd_en, s_bus.x_rd_en,
                     s_bus.y_valid, s_bus.y_ready, 32'(s_bus.b_addr), 32'(s_bus.w_addr),
                     32'(s_bus.x_addr), 32'(s_bus.y_addr), s_bus.y_data);
         checkOutput(1, d_busy, d_done, d_bus.b_rd_en, d_bus.w_rd_en, d_bus.x_rd_en,
                     d_bus.y_valid, d_bus.y_ready, 32'(d_bus.b_addr), 32'(d_bus.w_addr),
                     32'(d_bus.x_addr), 32'(d_bus.y_addr), d_bus.y_data);
      end
   end

   task automatic setStart(input int d, input logic v);
      if (d == 0) s_start = v; else d_start = v;
   endtask

   task automatic setRelu(input int d, input logic v);
      if (d == 0) s_relu = v; else d_relu = v;
   endtask

   function automatic logic yValid(input int d);
      return (d == 0) ? s_bus.y_valid : d_bus.y_valid;
   endfunction

   // One layer pass; optional backpressure at neuron 1, a stray start, or a reset abort.
   task automatic applyStimulus(input int d, input logic relu, input int stall_len,
                                input int mid_start_rel, input int abort_rel);
      int rel;
      int guard;
      int scnt;
      bit stalling;
      bit stall_done;
      computeModel(d, relu);
      for (int o = 0; o < n_out[d]; o++) got_y[d][o] = 16'hDEAD;
      @(posedge clk); #1;
      setStart(d, 1'b1);
      setRelu(d, relu);
      @(posedge clk); #1;
      setStart(d, 1'b0);
      setRelu(d, ~relu);
      start_cyc[d]   = cyc;
      nxt[d]         = 0;
      exp_w[d]       = 0;
      stall[d]       = 0;
      seen_valid[d]  = 1'b0;
      done_rel[d]    = -1;
      expect_idle[d] = 1'b0;
      active[d]      = 1'b1;
      guard = 0; scnt = 0; stalling = 1'b0; stall_done = 1'b0;
      while (active[d]) begin
         @(posedge clk); #1;
         guard++;
         rel = cyc - start_cyc[d] + 1;
         if (stall_len > 0 && !stall_done && !stalling && yValid(d) && nxt[d] == 1) begin
            ready_v[d] = 1'b0;
            stalling   = 1'b1;
            scnt       = 0;
         end else if (stalling) begin
            scnt++;
            if (scnt == stall_len) begin
               ready_v[d] = 1'b1;
               stalling   = 1'b0;
               stall_done = 1'b1;
            end
         end
         setStart(d, rel == mid_start_rel);
         if (rel == abort_rel) begin
            rst_n          = 1'b0;
            active[d]      = 1'b0;
            expect_idle[d] = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
         if (active[d] && guard > n_out[d]*(n_in[d]+3) + 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d pass_guard actual=%0d cycles required=pass end", d, guard);
            active[d] = 1'b0;
         end
      end
      ready_v[d] = 1'b1;
      setStart(d, 1'b0);
   endtask

   initial begin
      n_in  = '{SI, DI};
      n_out = '{SO, DO};
      active      = '{1'b0, 1'b0};
      expect_idle = '{1'b0, 1'b0};
      rst_n = 1'b0;
      s_start = 1'b0; s_relu = 1'b0;
      d_start = 1'b0; d_relu = 1'b0;
      ready_v[0] = 1'b1;
      ready_v[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkZero(0, s_busy, s_done, s_bus.b_rd_en, s_bus.w_rd_en, s_bus.x_rd_en, s_bus.y_valid,
                32'(s_bus.b_addr), 32'(s_bus.w_addr), 32'(s_bus.x_addr), 32'(s_bus.y_addr), s_bus.y_data);
      checkZero(1, d_busy, d_done, d_bus.b_rd_en, d_bus.w_rd_en, d_bus.x_rd_en, d_bus.y_valid,
                32'(d_bus.b_addr), 32'(d_bus.w_addr), 32'(d_bus.x_addr), 32'(d_bus.y_addr), d_bus.y_data);
      expect_idle[0] = 1'b1;
      expect_idle[1] = 1'b1;

      $display("[TB] 4x3: 1.0*1.0 with bias 0.5");
      fillConst(0, 16'h0100, 16'h0100, 16'h0080);
      applyStimulus(0, 1'b0, 0, 0, 0);
      checkLiteral(0, 16'h0480);
      checkValue(0, "done_cycle_literal", done_rel[0], 22);

      $display("[TB] 4x3: positive and negative saturation");
      fillConst(0, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      applyStimulus(0, 1'b0, 0, 0, 0);
      checkLiteral(0, 16'h7FFF);
      fillConst(0, 16'h8000, 16'h7FFF, 16'h0000);
      applyStimulus(0, 1'b0, 0, 0, 0);
      checkLiteral(0, 16'h8000);

      $display("[TB] 4x3: ReLU on and off");
      fillConst(0, 16'h0100, 16'hFF00, 16'h0000);
      applyStimulus(0, 1'b1, 0, 0, 0);
      checkLiteral(0, 16'h0000);
      applyStimulus(0, 1'b0, 0, 0, 0);
      checkLiteral(0, 16'hFC00);

      $display("[TB] 4x3: backpressure at neuron 1");
      fillRandom(0);
      applyStimulus(0, 1'($urandom_range(0, 1)), 5, 0, 0);
      checkValue(0, "stall_cycles", stall[0], 5);
      checkValue(0, "done_cycle_stalled", done_rel[0], 27);

      $display("[TB] 4x3: reset during neuron 1 MAC, then rerun");
      fillRandom(0);
      applyStimulus(0, 1'b0, 0, 0, 10);
      @(negedge clk);
      checkZero(0, s_busy, s_done, s_bus.b_rd_en, s_bus.w_rd_en, s_bus.x_rd_en, s_bus.y_valid,
                32'(s_bus.b_addr), 32'(s_bus.w_addr), 32'(s_bus.x_addr), 32'(s_bus.y_addr), s_bus.y_data);
      expect_idle[0] = 1'b1;
      applyStimulus(0, 1'b1, 0, 0, 0);
      checkValue(0, "done_cycle_rerun", done_rel[0], 22);

      $display("[TB] 120x84: random data with a stray start mid-pass");
      fillRandom(1);
      applyStimulus(1, 1'($urandom_range(0, 1)), 0, 500, 0);
      checkValue(1, "done_cycle_literal", done_rel[1], 10333);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
